// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: FSM state encoding,
// opcode and ALU-op constants, pcSrc / aluSrcB encodings and the opcode
// decoder used in the DECODE state.
package ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch, StDecode, StExecR, StWbR, StExecI, StWbI, StMemAddr,
        StMemRd, StMemWr, StWbMem, StBranch, StJump, StJal, StJr, StTrap
    } state_e;

    // Opcodes (R-type ops occupy OP_ADD..OP_SGT, with OP_JR carved out of that range)
    localparam logic [4:0] OP_ADD  = 5'b01000;
    localparam logic [4:0] OP_SUB  = 5'b01001;
    localparam logic [4:0] OP_JR   = 5'b10010;
    localparam logic [4:0] OP_SGT  = 5'b10100;
    localparam logic [4:0] OP_ADDI = 5'b11000;
    localparam logic [4:0] OP_SUBI = 5'b11001;
    localparam logic [4:0] OP_LW   = 5'b11010;
    localparam logic [4:0] OP_SW   = 5'b11011;
    localparam logic [4:0] OP_BEQ  = 5'b11100;
    localparam logic [4:0] OP_BNE  = 5'b11101;
    localparam logic [4:0] OP_J    = 5'b00000;
    localparam logic [4:0] OP_JAL  = 5'b00111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    localparam logic [1:0] PC_SRC_ALU  = 2'b00;
    localparam logic [1:0] PC_SRC_JUMP = 2'b01;
    localparam logic [1:0] PC_SRC_REG  = 2'b10;

    localparam logic [1:0] ALU_B_REG = 2'b00;
    localparam logic [1:0] ALU_B_ONE = 2'b01;
    localparam logic [1:0] ALU_B_IMM = 2'b10;

    // State following DECODE for a given opcode; StTrap marks an illegal opcode.
    function automatic state_e decode_op(input logic [4:0] op);
        state_e nxt;
        if (op == OP_JR) begin
            nxt = StJr;
        end else if (op >= OP_ADD && op <= OP_SGT) begin
            nxt = StExecR;
        end else begin
            case (op)
                OP_ADDI, OP_SUBI: nxt = StExecI;
                OP_LW, OP_SW:     nxt = StMemAddr;
                OP_BEQ, OP_BNE:   nxt = StBranch;
                OP_J:             nxt = StJump;
                OP_JAL:           nxt = StJal;
                default:          nxt = StTrap;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Memory-wait timeout counter.
// Ports: clk, reset (sync, active-high), clear (highest priority), enable
// (count one waiting cycle), expired (this enabled cycle is the last one
// allowed; the controller traps at the coming edge).
module mem_timeout_ctr #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TO_W        = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TO_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires on the MEM_TIMEOUT-th waiting cycle, so a request is held for
    // exactly MEM_TIMEOUT cycles before the fault.
    assign expired = enable && (count_q == TO_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control FSM for the 5-bit-opcode ISA.
// Inputs : clk, reset (sync, active-high), opCode, zero, memReady.
// Outputs: memory handshake (memReq, memWrite, iOrD), datapath enables
//          (irWrite, pcWrite, regWrite), muxes (pcSrc, regDst, memToReg,
//          jalSelect, aluSrcA, aluSrcB), aluControl, sticky traps
//          (illegal, memFault).
// Outputs are decoded from the registered state; the only input-qualified
// strobes are the FETCH completion (memReady) and the branch pcWrite (zero).
module multi_cycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TO_W        = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] opCode,
    input  logic       zero,
    input  logic       memReady,
    output logic       memReq,
    output logic       memWrite,
    output logic       iOrD,
    output logic       irWrite,
    output logic       pcWrite,
    output logic [1:0] pcSrc,
    output logic       regWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic       jalSelect,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [3:0] aluControl,
    output logic       illegal,
    output logic       memFault
);

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   mem_fault_q, mem_fault_d;
    logic   in_req, to_clear, to_enable, to_expired;

    assign in_req    = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    assign to_enable = in_req && !memReady;
    assign to_clear  = memReady || (state_d != state_q);

    mem_timeout_ctr #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TO_W       (TO_W)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (to_clear),
        .enable (to_enable),
        .expired(to_expired)
    );

    always_comb begin
        state_d     = state_q;
        illegal_d   = illegal_q;
        mem_fault_d = mem_fault_q;
        memReq      = 1'b0;
        memWrite    = 1'b0;
        iOrD        = 1'b0;
        irWrite     = 1'b0;
        pcWrite     = 1'b0;
        pcSrc       = PC_SRC_ALU;
        regWrite    = 1'b0;
        regDst      = 1'b0;
        memToReg    = 1'b0;
        jalSelect   = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = ALU_B_REG;
        aluControl  = ALU_ADD;

        case (state_q)
            StFetch: begin
                memReq = 1'b1;
                // Load IR and bump PC (PC + 1) only when the fetch completes.
                if (memReady) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    aluSrcB = ALU_B_ONE;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = decode_op(opCode);
                if (state_d == StTrap) begin
                    illegal_d = 1'b1;
                end
            end
            StExecR: begin
                aluSrcA    = 1'b1;
                aluControl = 4'(opCode - OP_ADD);
                state_d    = StWbR;
            end
            StWbR: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
                state_d  = StFetch;
            end
            StExecI: begin
                aluSrcA    = 1'b1;
                aluSrcB    = ALU_B_IMM;
                aluControl = (opCode == OP_SUBI) ? ALU_SUB : ALU_ADD;
                state_d    = StWbI;
            end
            StWbI: begin
                regWrite = 1'b1;
                state_d  = StFetch;
            end
            StMemAddr: begin
                aluSrcA = 1'b1;
                aluSrcB = ALU_B_IMM;
                state_d = (opCode == OP_SW) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                memReq = 1'b1;
                iOrD   = 1'b1;
                if (memReady) begin
                    state_d = StWbMem;
                end
            end
            StMemWr: begin
                memReq   = 1'b1;
                iOrD     = 1'b1;
                memWrite = 1'b1;
                if (memReady) begin
                    state_d = StFetch;
                end
            end
            StWbMem: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
                state_d  = StFetch;
            end
            StBranch: begin
                aluSrcA    = 1'b1;
                aluControl = ALU_SUB;
                pcWrite    = (opCode == OP_BNE) ? !zero : zero;
                state_d    = StFetch;
            end
            StJump: begin
                pcWrite = 1'b1;
                pcSrc   = PC_SRC_JUMP;
                state_d = StFetch;
            end
            StJal: begin
                regWrite  = 1'b1;
                jalSelect = 1'b1;
                pcWrite   = 1'b1;
                pcSrc     = PC_SRC_JUMP;
                state_d   = StFetch;
            end
            StJr: begin
                pcWrite = 1'b1;
                pcSrc   = PC_SRC_REG;
                state_d = StFetch;
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        // Only active while waiting on memory, so it never races a completion.
        if (to_expired) begin
            state_d     = StTrap;
            mem_fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StFetch;
            illegal_q   <= 1'b0;
            mem_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            illegal_q   <= illegal_d;
            mem_fault_q <= mem_fault_d;
        end
    end

    assign illegal  = illegal_q;
    assign memFault = mem_fault_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: a hand-written table of
// single-instruction vectors, hand sequences for waits, traps, timeouts and
// reset, and randomized instruction streams checked against a per-instruction
// cycle-script model.
module tb_multi_cycle_ctrl;

    typedef struct packed {
        logic       mr;
        logic       mw;
        logic       io;
        logic       ir;
        logic       pw;
        logic [1:0] ps;
        logic       rw;
        logic       rd;
        logic       m2r;
        logic       jal;
        logic       asa;
        logic [1:0] asb;
        logic [3:0] ac;
        logic       ill;
        logic       flt;
    } out_t;

    typedef struct {
        logic       rdy;
        logic [4:0] op;
        logic       zero;
        out_t       exp;
    } cyc_t;

    typedef struct {
        logic [4:0] op;
        logic       z;
        int         len;
        out_t       c2;
        out_t       c3;
        out_t       c4;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] opCode;
    logic       zero;
    logic       memReady;
    logic       memReq, memWrite, iOrD, irWrite, pcWrite;
    logic [1:0] pcSrc;
    logic       regWrite, regDst, memToReg, jalSelect, aluSrcA;
    logic [1:0] aluSrcB;
    logic [3:0] aluControl;
    logic       illegal, memFault;
    out_t       act;

    int checks = 0;
    int errors = 0;

    cyc_t       script[$];
    logic [4:0] cur_op;
    logic       cur_zero;

    multi_cycle_ctrl #(
        .MEM_TIMEOUT(16),
        .TO_W       (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .opCode    (opCode),
        .zero      (zero),
        .memReady  (memReady),
        .memReq    (memReq),
        .memWrite  (memWrite),
        .iOrD      (iOrD),
        .irWrite   (irWrite),
        .pcWrite   (pcWrite),
        .pcSrc     (pcSrc),
        .regWrite  (regWrite),
        .regDst    (regDst),
        .memToReg  (memToReg),
        .jalSelect (jalSelect),
        .aluSrcA   (aluSrcA),
        .aluSrcB   (aluSrcB),
        .aluControl(aluControl),
        .illegal   (illegal),
        .memFault  (memFault)
    );

    always #5 clk = ~clk;

    assign act = {memReq, memWrite, iOrD, irWrite, pcWrite, pcSrc, regWrite, regDst,
                  memToReg, jalSelect, aluSrcA, aluSrcB, aluControl, illegal, memFault};

    function automatic out_t mk(input logic mr, input logic mw, input logic io,
                                input logic ir, input logic pw, input logic [1:0] ps,
                                input logic rw, input logic rd, input logic m2r,
                                input logic jal, input logic asa, input logic [1:0] asb,
                                input logic [3:0] ac);
        out_t o;
        o = '{mr, mw, io, ir, pw, ps, rw, rd, m2r, jal, asa, asb, ac, 1'b0, 1'b0};
        return o;
    endfunction

    task automatic check_out(input string name, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h", name, act, exp);
        end
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic step(input string name, input logic rdy, input out_t exp);
        memReady = rdy;
        @(negedge clk);
        check_out(name, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        memReady = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- reference model: instruction -> cycle script ----------------
    function automatic void push(input logic rdy, input out_t e);
        cyc_t c;
        c.rdy  = rdy;
        c.op   = cur_op;
        c.zero = cur_zero;
        c.exp  = e;
        script.push_back(c);
    endfunction

    function automatic out_t fault_out();
        out_t t = '0;
        t.flt = 1'b1;
        return t;
    endfunction

    // A memory wait of w cycles; 16 or more waits end in a memory-fault trap.
    function automatic bit req_phase(input out_t waiting, input out_t done, input int w);
        if (w >= 16) begin
            for (int i = 0; i < 16; i++) push(1'b0, waiting);
            for (int i = 0; i < 3; i++) push(1'($urandom_range(0, 1)), fault_out());
            return 1'b1;
        end
        for (int i = 0; i < w; i++) push(1'b0, waiting);
        push(1'b1, done);
        return 1'b0;
    endfunction

    function automatic void gen_instr(input logic [4:0] op, input logic z, input int fw,
                                      input int mw);
        out_t f_wait, f_done, addr_o, rd_o, wr_o, t;
        int   v;
        cur_op   = op;
        cur_zero = z;
        v        = int'(op);
        f_wait = mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 4'h0);
        f_done = mk(1, 0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0, 2'b01, 4'h0);
        addr_o = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 2'b10, 4'h0);
        rd_o   = mk(1, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 4'h0);
        wr_o   = mk(1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 4'h0);
        if (req_phase(f_wait, f_done, fw)) return;
        push(1'($urandom_range(0, 1)), '0);
        if (v >= 8 && v <= 20 && v != 18) begin
            push(1'($urandom_range(0, 1)),
                 mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 2'b00, 4'(v - 8)));
            push(1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0, 0, 2'b00, 4'h0));
        end else if (v == 18) begin
            push(1'b0, mk(0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 0, 0, 2'b00, 4'h0));
        end else if (v == 24 || v == 25) begin
            push(1'b1, mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 2'b10, (v == 25) ? 4'h1 : 4'h0));
            push(1'b0, mk(0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 2'b00, 4'h0));
        end else if (v == 26) begin
            push(1'b1, addr_o);
            if (req_phase(rd_o, rd_o, mw)) return;
            push(1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 0, 2'b00, 1, 0, 1, 0, 0, 2'b00, 4'h0));
        end else if (v == 27) begin
            push(1'b1, addr_o);
            void'(req_phase(wr_o, wr_o, mw));
        end else if (v == 28 || v == 29) begin
            push(1'($urandom_range(0, 1)),
                 mk(0, 0, 0, 0, (v == 28) ? z : !z, 2'b00, 0, 0, 0, 0, 1, 2'b00, 4'h1));
        end else if (v == 0) begin
            push(1'b1, mk(0, 0, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0, 2'b00, 4'h0));
        end else if (v == 7) begin
            push(1'b0, mk(0, 0, 0, 0, 1, 2'b01, 1, 0, 0, 1, 0, 2'b00, 4'h0));
        end else begin
            t     = '0;
            t.ill = 1'b1;
            for (int i = 0; i < 10; i++) push(1'($urandom_range(0, 1)), t);
        end
    endfunction

    task automatic run_script(input string tag);
        cyc_t c;
        int   n = 0;
        while (script.size() > 0) begin
            c      = script.pop_front();
            opCode = c.op;
            zero   = c.zero;
            step($sformatf("%s[%0d]", tag, n), c.rdy, c.exp);
            n++;
        end
    endtask

    // ---------------------------------- test ----------------------------------
    vec_t       tbl[14];
    out_t       fetch_o, wait_o, e;
    logic [4:0] legal_ops[13];
    int         fw, mw;

    initial begin
        fetch_o = mk(1, 0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0, 2'b01, 4'h0);
        wait_o  = mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 4'h0);
        //          op        z     len exec-cycle / following cycles
        tbl[0]  = '{5'b01000, 1'b0, 4, mk(0,0,0,0,0,2'b00,0,0,0,0,1,2'b00,4'h0),
                    mk(0,0,0,0,0,2'b00,1,1,0,0,0,2'b00,4'h0), '0};
        tbl[1]  = '{5'b01001, 1'b0, 4, mk(0,0,0,0,0,2'b00,0,0,0,0,1,2'b00,4'h1),
                    mk(0,0,0,0,0,2'b00,1,1,0,0,0,2'b00,4'h0), '0};
        tbl[2]  = '{5'b10100, 1'b0, 4, mk(0,0,0,0,0,2'b00,0,0,0,0,1,2'b00,4'hc),
                    mk(0,0,0,0,0,2'b00,1,1,0,0,0,2'b00,4'h0), '0};
        tbl[3]  = '{5'b11000, 1'b0, 4, mk(0,0,0,0,0,2'b00,0,0,0,0,1,2'b10,4'h0),
                    mk(0,0,0,0,0,2'b00,1,0,0,0,0,2'b00,4'h0), '0};
        tbl[4]  = '{5'b11001, 1'b0, 4, mk(0,0,0,0,0,2'b00,0,0,0,0,1,2'b10,4'h1),
                    mk(0,0,0,0,0,2'b00,1,0,0,0,0,2'b00,4'h0), '0};
        tbl[5]  = '{5'b11010, 1'b0, 5, mk(0,0,0,0,0,2'b00,0,0,0,0,1,2'b10,4'h0),
                    mk(1,0,1,0,0,2'b00,0,0,0,0,0,2'b00,4'h0),
                    mk(0,0,0,0,0,2'b00,1,0,1,0,0,2'b00,4'h0)};
        tbl[6]  = '{5'b11011, 1'b0, 4, mk(0,0,0,0,0,2'b00,0,0,0,0,1,2'b10,4'h0),
                    mk(1,1,1,0,0,2'b00,0,0,0,0,0,2'b00,4'h0), '0};
        tbl[7]  = '{5'b11100, 1'b1, 3, mk(0,0,0,0,1,2'b00,0,0,0,0,1,2'b00,4'h1), '0, '0};
        tbl[8]  = '{5'b11100, 1'b0, 3, mk(0,0,0,0,0,2'b00,0,0,0,0,1,2'b00,4'h1), '0, '0};
        tbl[9]  = '{5'b11101, 1'b1, 3, mk(0,0,0,0,0,2'b00,0,0,0,0,1,2'b00,4'h1), '0, '0};
        tbl[10] = '{5'b11101, 1'b0, 3, mk(0,0,0,0,1,2'b00,0,0,0,0,1,2'b00,4'h1), '0, '0};
        tbl[11] = '{5'b00000, 1'b0, 3, mk(0,0,0,0,1,2'b01,0,0,0,0,0,2'b00,4'h0), '0, '0};
        tbl[12] = '{5'b00111, 1'b0, 3, mk(0,0,0,0,1,2'b01,1,0,0,1,0,2'b00,4'h0), '0, '0};
        tbl[13] = '{5'b10010, 1'b0, 3, mk(0,0,0,0,1,2'b10,0,0,0,0,0,2'b00,4'h0), '0, '0};

        legal_ops = '{5'b01000, 5'b01011, 5'b10001, 5'b10011, 5'b10100, 5'b10010, 5'b11000,
                      5'b11001, 5'b11010, 5'b11011, 5'b11100, 5'b11101, 5'b00111};

        opCode = 5'b00000;
        zero   = 1'b0;
        do_reset();
        step("reset_fetch", 1'b0, wait_o);

        // Table vectors, memReady high every cycle.
        for (int i = 0; i < 14; i++) begin
            opCode = tbl[i].op;
            zero   = tbl[i].z;
            for (int k = 0; k < tbl[i].len; k++) begin
                e = (k == 0) ? fetch_o : (k == 1) ? '0 : (k == 2) ? tbl[i].c2 :
                    (k == 3) ? tbl[i].c3 : tbl[i].c4;
                step($sformatf("tbl%0d_c%0d", i, k), 1'b1, e);
            end
        end

        // lw with three wait cycles in MEM_RD.
        gen_instr(5'b11010, 1'b0, 0, 3);
        run_script("lw_wait");

        // Randomized instruction stream with random memory waits.
        for (int i = 0; i < 150; i++) begin
            fw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
            mw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
            if ($urandom_range(0, 3) == 0) begin
                gen_instr(5'($urandom_range(0, 31)) == 5'b00000 ? 5'b00000 : 5'b00000,
                          1'($urandom_range(0, 1)), fw, mw);
            end else begin
                gen_instr(legal_ops[$urandom_range(0, 12)], 1'($urandom_range(0, 1)), fw, mw);
            end
            run_script($sformatf("rnd%0d", i));
        end

        // Illegal opcode: trap, held for 10 cycles, cleared by reset.
        gen_instr(5'b00101, 1'b0, 0, 0);
        run_script("illegal");
        do_reset();
        step("after_trap_reset", 1'b0, wait_o);
        gen_instr(5'b11110, 1'b0, 1, 0);
        run_script("illegal2");

        // Fetch timeout: memFault after exactly 16 waiting cycles.
        do_reset();
        gen_instr(5'b01000, 1'b0, 16, 0);
        run_script("fetch_timeout");

        // Reset on the 8th waiting cycle restarts the count from zero.
        do_reset();
        for (int i = 0; i < 7; i++) step($sformatf("pre_rst%0d", i), 1'b0, wait_o);
        reset = 1'b1;
        step("rst_cycle8", 1'b0, wait_o);
        reset = 1'b0;
        gen_instr(5'b01000, 1'b0, 15, 0);
        run_script("post_rst");

        // Timeouts in MEM_WR and MEM_RD.
        do_reset();
        gen_instr(5'b11011, 1'b0, 0, 16);
        run_script("sw_timeout");
        do_reset();
        gen_instr(5'b11010, 1'b0, 2, 16);
        run_script("lw_timeout");
        do_reset();
        gen_instr(5'b11010, 1'b0, 0, 15);
        run_script("lw_wait15");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
